// File: rtl/vga_controller.sv
// vga_controller: pixel timing generator and video output stage for a
// 640x480@60 VGA port. Counts h/v position, hands the visible coordinate to
// the framebuffer, delays timing flags to meet the returning pixel data, then
// registers expanded BBGGGRRR colour, syncs and blank for the DAC. The frame
// selection is latched once per frame at the start of vertical blanking.
module vga_controller #(
  parameter int H_VISIBLE    = 640,
  parameter int H_FRONT      = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BACK       = 48,
  parameter int V_VISIBLE    = 480,
  parameter int V_FRONT      = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BACK       = 33,
  parameter int READ_LATENCY = 1
) (
  input  logic       clock_video,
  input  logic       reset,
  output logic [9:0] pixel_x_pos,
  output logic [9:0] pixel_y_pos,
  input  logic [7:0] pixel_frame0,
  input  logic [7:0] pixel_frame1,
  input  logic       frame_select,
  output logic [7:0] vga_r,
  output logic [7:0] vga_g,
  output logic [7:0] vga_b,
  output logic       vga_hsync_n,
  output logic       vga_vsync_n,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       active_frame,
  output logic       vblank_pulse
);

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_STOP  = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_STOP  = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0] h_q, h_d, v_q, v_d;
  logic       visible, hsync, vsync, frame_start;

  // Timing flags are stored active-high; index 0 is the newest stage.
  logic [READ_LATENCY-1:0] vis_dl_q, hs_dl_q, vs_dl_q, af_dl_q;
  logic                    vis_t, hs_t, vs_t, af_t;

  logic [7:0] pix, r_d, g_d, b_d;
  logic [7:0] r_q, g_q, b_q;
  logic       hsync_n_q, vsync_n_q, blank_n_q;
  logic       active_q, vblank_q;

  // Next position: h wraps every line, v advances on h wrap and wraps per frame.
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  // Decode the current position into timing flags.
  always_comb begin
    visible     = (h_q < H_VIS) && (v_q < V_VIS);
    hsync       = (h_q >= HS_START) && (h_q < HS_STOP);
    vsync       = (v_q >= VS_START) && (v_q < VS_STOP);
    frame_start = (h_q == '0) && (v_q == V_VIS);
  end

  assign pixel_x_pos = visible ? h_q : '0;
  assign pixel_y_pos = visible ? v_q : '0;

  // Position counters.
  always_ff @(posedge clock_video or posedge reset) begin
    if (reset) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Frame latch at the start of vertical blanking plus the one-cycle pulse.
  always_ff @(posedge clock_video or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      vblank_q <= 1'b0;
    end else begin
      if (frame_start) active_q <= frame_select;
      vblank_q <= frame_start;
    end
  end

  // Delay line matching the framebuffer read latency.
  always_ff @(posedge clock_video or posedge reset) begin
    if (reset) begin
      vis_dl_q <= '0;
      hs_dl_q  <= '0;
      vs_dl_q  <= '0;
      af_dl_q  <= '0;
    end else begin
      vis_dl_q[0] <= visible;
      hs_dl_q[0]  <= hsync;
      vs_dl_q[0]  <= vsync;
      af_dl_q[0]  <= active_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vis_dl_q[i] <= vis_dl_q[i-1];
        hs_dl_q[i]  <= hs_dl_q[i-1];
        vs_dl_q[i]  <= vs_dl_q[i-1];
        af_dl_q[i]  <= af_dl_q[i-1];
      end
    end
  end

  assign vis_t = vis_dl_q[READ_LATENCY-1];
  assign hs_t  = hs_dl_q[READ_LATENCY-1];
  assign vs_t  = vs_dl_q[READ_LATENCY-1];
  assign af_t  = af_dl_q[READ_LATENCY-1];

  // Select the displayed frame's pixel and replicate bits up to 8-bit channels.
  always_comb begin
    pix = af_t ? pixel_frame1 : pixel_frame0;
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (vis_t) begin
      r_d = {pix[2:0], pix[2:0], pix[2:1]};
      g_d = {pix[5:3], pix[5:3], pix[5:4]};
      b_d = {pix[7:6], pix[7:6], pix[7:6], pix[7:6]};
    end
  end

  // Registered video outputs.
  always_ff @(posedge clock_video or posedge reset) begin
    if (reset) begin
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hsync_n_q <= ~hs_t;
      vsync_n_q <= ~vs_t;
      blank_n_q <= vis_t;
    end
  end

  assign vga_r        = r_q;
  assign vga_g        = g_q;
  assign vga_b        = b_q;
  assign vga_hsync_n  = hsync_n_q;
  assign vga_vsync_n  = vsync_n_q;
  assign vga_blank_n  = blank_n_q;
  assign vga_sync_n   = 1'b0;
  assign active_frame = active_q;
  assign vblank_pulse = vblank_q;

endmodule

// File: tb/tb_vga_controller.sv
// Bench for vga_controller: one full-size instance (READ_LATENCY=1) and two
// reduced-geometry instances (READ_LATENCY=3 and 1) checked cycle by cycle
// against a position/arithmetic reference model.
module tb_vga_controller;

  localparam int N = 3;
  localparam int SHV = 40, SHF = 4, SHS = 8, SHB = 6;
  localparam int SVV = 12, SVF = 2, SVS = 2, SVB = 3;

  localparam int HV_A [N] = '{640, SHV, SHV};
  localparam int HF_A [N] = '{16,  SHF, SHF};
  localparam int HS_A [N] = '{96,  SHS, SHS};
  localparam int HB_A [N] = '{48,  SHB, SHB};
  localparam int VV_A [N] = '{480, SVV, SVV};
  localparam int VF_A [N] = '{10,  SVF, SVF};
  localparam int VS_A [N] = '{2,   SVS, SVS};
  localparam int VB_A [N] = '{33,  SVB, SVB};
  localparam int RL_A [N] = '{1,   3,   1};

  localparam logic [49:0] RESET_VEC = {10'd0, 10'd0, 24'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [N] = '{1'b1, 1'b1, 1'b1};
  logic       fs  [N] = '{1'b0, 1'b0, 1'b0};
  logic [9:0] px [N], py [N];
  logic [7:0] f0 [N], f1 [N], vr [N], vg [N], bo [N];
  logic       hs_n [N], vs_n [N], bl_n [N], sy_n [N], af [N], vbp [N];

  int   errors = 0;
  int   checks = 0;
  int   k    [N];
  logic af_m [N];
  logic vb_m [N];
  logic [7:0] tbl [2][SVV][SHV];

  vga_controller #(.READ_LATENCY(1)) u_full (
    .clock_video(clk), .reset(rst[0]), .pixel_x_pos(px[0]), .pixel_y_pos(py[0]),
    .pixel_frame0(f0[0]), .pixel_frame1(f1[0]), .frame_select(fs[0]),
    .vga_r(vr[0]), .vga_g(vg[0]), .vga_b(bo[0]), .vga_hsync_n(hs_n[0]),
    .vga_vsync_n(vs_n[0]), .vga_blank_n(bl_n[0]), .vga_sync_n(sy_n[0]),
    .active_frame(af[0]), .vblank_pulse(vbp[0]));

  vga_controller #(.H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
                   .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
                   .READ_LATENCY(3)) u_small3 (
    .clock_video(clk), .reset(rst[1]), .pixel_x_pos(px[1]), .pixel_y_pos(py[1]),
    .pixel_frame0(f0[1]), .pixel_frame1(f1[1]), .frame_select(fs[1]),
    .vga_r(vr[1]), .vga_g(vg[1]), .vga_b(bo[1]), .vga_hsync_n(hs_n[1]),
    .vga_vsync_n(vs_n[1]), .vga_blank_n(bl_n[1]), .vga_sync_n(sy_n[1]),
    .active_frame(af[1]), .vblank_pulse(vbp[1]));

  vga_controller #(.H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
                   .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
                   .READ_LATENCY(1)) u_small1 (
    .clock_video(clk), .reset(rst[2]), .pixel_x_pos(px[2]), .pixel_y_pos(py[2]),
    .pixel_frame0(f0[2]), .pixel_frame1(f1[2]), .frame_select(fs[2]),
    .vga_r(vr[2]), .vga_g(vg[2]), .vga_b(bo[2]), .vga_hsync_n(hs_n[2]),
    .vga_vsync_n(vs_n[2]), .vga_blank_n(bl_n[2]), .vga_sync_n(sy_n[2]),
    .active_frame(af[2]), .vblank_pulse(vbp[2]));

  // ---------------- reference model ----------------
  function automatic int ht(int i);
    return HV_A[i] + HF_A[i] + HS_A[i] + HB_A[i];
  endfunction

  function automatic int vt(int i);
    return VV_A[i] + VF_A[i] + VS_A[i] + VB_A[i];
  endfunction

  function automatic int flen(int i);
    return ht(i) * vt(i);
  endfunction

  // Frame content: full instance returns x (frame 1 scrambled), small ones use random tables.
  function automatic logic [7:0] pix_of(int i, logic f, int x, int y);
    if (i == 0) return f ? (8'(x) ^ 8'h5A) : 8'(x);
    if (x < SHV && y < SVV) return tbl[f][y][x];
    return 8'h00;
  endfunction

  function automatic logic [23:0] expand(logic [7:0] p);
    int r3, g3, b2, r, g, b;
    r3 = int'(p) % 8;
    g3 = (int'(p) / 8) % 8;
    b2 = int'(p) / 64;
    r = r3 * 32 + r3 * 4 + r3 / 2;
    g = g3 * 32 + g3 * 4 + g3 / 2;
    b = b2 * 85;
    return {8'(r), 8'(g), 8'(b)};
  endfunction

  // Expected {x, y, rgb, hsync_n, vsync_n, blank_n, sync_n, active_frame, vblank} after k edges.
  function automatic logic [49:0] model_vec(int i);
    int p, h, v, q, hq, vq;
    logic vis, hsa, vsa;
    logic [23:0] rgb;
    logic [9:0] xo, yo;
    p = k[i] % flen(i);
    h = p % ht(i);
    v = p / ht(i);
    xo = '0;
    yo = '0;
    if (h < HV_A[i] && v < VV_A[i]) begin
      xo = 10'(h);
      yo = 10'(v);
    end
    vis = 1'b0; hsa = 1'b0; vsa = 1'b0; rgb = '0;
    q = k[i] - RL_A[i] - 1;
    if (q >= 0) begin
      q   = q % flen(i);
      hq  = q % ht(i);
      vq  = q / ht(i);
      vis = (hq < HV_A[i]) && (vq < VV_A[i]);
      hsa = (hq >= HV_A[i] + HF_A[i]) && (hq < HV_A[i] + HF_A[i] + HS_A[i]);
      vsa = (vq >= VV_A[i] + VF_A[i]) && (vq < VV_A[i] + VF_A[i] + VS_A[i]);
      if (vis) rgb = expand(pix_of(i, af_m[i], hq, vq));
    end
    return {xo, yo, rgb, ~hsa, ~vsa, vis, 1'b0, af_m[i], vb_m[i]};
  endfunction

  function automatic logic [49:0] dut_vec(int i);
    return {px[i], py[i], vr[i], vg[i], bo[i], hs_n[i], vs_n[i], bl_n[i], sy_n[i], af[i], vbp[i]};
  endfunction

  // Framebuffer model: registered read pipeline READ_LATENCY deep per instance.
  logic [7:0] pipe0 [N][3];
  logic [7:0] pipe1 [N][3];
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      pipe0[i][0] <= pix_of(i, 1'b0, int'(px[i]), int'(py[i]));
      pipe1[i][0] <= pix_of(i, 1'b1, int'(px[i]), int'(py[i]));
      for (int j = 1; j < 3; j++) begin
        pipe0[i][j] <= pipe0[i][j-1];
        pipe1[i][j] <= pipe1[i][j-1];
      end
    end
  end
  assign f0[0] = pipe0[0][RL_A[0]-1];
  assign f1[0] = pipe1[0][RL_A[0]-1];
  assign f0[1] = pipe0[1][RL_A[1]-1];
  assign f1[1] = pipe1[1][RL_A[1]-1];
  assign f0[2] = pipe0[2][RL_A[2]-1];
  assign f1[2] = pipe1[2][RL_A[2]-1];

  // ---------------- driver ----------------
  // One clock edge; the model advances with the DUTs, outputs sampled 1 ns later.
  task automatic step();
    int p;
    @(posedge clk);
    for (int i = 0; i < N; i++) begin
      if (rst[i]) begin
        k[i] = 0; af_m[i] = 1'b0; vb_m[i] = 1'b0;
      end else begin
        p = k[i] % flen(i);
        vb_m[i] = (p == VV_A[i] * ht(i));
        if (vb_m[i]) af_m[i] = fs[i];
        k[i]++;
      end
    end
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < N; i++) begin
      rst[i] = 1'b1; fs[i] = 1'b0; k[i] = 0; af_m[i] = 1'b0; vb_m[i] = 1'b0;
    end
    for (int f = 0; f < 2; f++)
      for (int y = 0; y < SVV; y++)
        for (int x = 0; x < SHV; x++)
          tbl[f][y][x] = 8'($urandom_range(0, 255));
    tbl[0][0][0] = 8'hFF;
    tbl[0][0][1] = 8'hC0;
    tbl[0][0][2] = 8'h38;
    tbl[0][0][3] = 8'h07;
    repeat (3) step();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (dut_vec(i) !== RESET_VEC) begin
        errors++;
        $display("FAIL reset_values inst=%0d got=%h exp=%h", i, dut_vec(i), RESET_VEC);
      end
      rst[i] = 1'b0;
    end
  endtask

  task automatic test_hsync_timing();
    int first_low, low_cnt;
    logic prev;
    logic [49:0] ev, dv;
    first_low = -1; low_cnt = 0; prev = 1'b1;
    for (int c = 0; c < 2400; c++) begin
      if ($urandom_range(0, 99) == 0) fs[0] = ~fs[0];
      step();
      for (int i = 0; i < N; i++) begin
        ev = model_vec(i); dv = dut_vec(i);
        checks++;
        if (dv !== ev) begin
          errors++;
          $display("FAIL line_video inst=%0d k=%0d got=%h exp=%h", i, k[i], dv, ev);
        end
      end
      if (k[0] == 7) begin
        checks++;
        if ({vr[0], vg[0], bo[0]} !== 24'hB60000) begin
          errors++;
          $display("FAIL rgb_x5 got=%h exp=%h", {vr[0], vg[0], bo[0]}, 24'hB60000);
        end
      end
      if (prev && !hs_n[0] && first_low < 0) first_low = k[0];
      if (!hs_n[0]) low_cnt++;
      prev = hs_n[0];
    end
    checks++;
    if (first_low != 658) begin
      errors++;
      $display("FAIL hsync_first_low got=%0d exp=658", first_low);
    end
    checks++;
    if (low_cnt != 288) begin
      errors++;
      $display("FAIL hsync_low_cycles got=%0d exp=288", low_cnt);
    end
  endtask

  task automatic test_colour();
    logic [23:0] lit [4] = '{24'hFFFFFF, 24'h0000FF, 24'h00FF00, 24'hFF0000};
    logic [49:0] ev, dv;
    int q;
    fs[1] = 1'b0; fs[2] = 1'b0;
    for (int c = 0; c < flen(1) + 4; c++) begin
      step();
      for (int i = 1; i < N; i++) begin
        ev = model_vec(i); dv = dut_vec(i);
        checks++;
        if (dv !== ev) begin
          errors++;
          $display("FAIL colour_video inst=%0d k=%0d got=%h exp=%h", i, k[i], dv, ev);
        end
        q = k[i] - RL_A[i] - 1;
        if (q >= 0 && q % flen(i) < 4) begin
          checks++;
          if ({vr[i], vg[i], bo[i]} !== lit[q % flen(i)]) begin
            errors++;
            $display("FAIL colour_expand inst=%0d px=%0d got=%h exp=%h",
                     i, q % flen(i), {vr[i], vg[i], bo[i]}, lit[q % flen(i)]);
          end
        end
      end
    end
  endtask

  task automatic test_frame_switch();
    int target, pulses, last_pulse;
    logic found;
    logic [49:0] ev, dv;
    fs[1] = 1'b0; fs[2] = 1'b0;
    target = 5 * ht(1) + 20;
    found = 1'b0;
    for (int c = 0; c < 2 * flen(1); c++) begin
      if (k[1] % flen(1) == target) begin found = 1'b1; break; end
      step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL switch_wait got=timeout exp=position(20,5)");
    end
    fs[1] = 1'b1; fs[2] = 1'b1;
    pulses = 0; last_pulse = -1;
    for (int c = 0; c < 3 * flen(1); c++) begin
      if (pulses > 0 && $urandom_range(0, 149) == 0) fs[1] = ~fs[1];
      if (pulses > 0 && $urandom_range(0, 149) == 0) fs[2] = ~fs[2];
      step();
      for (int i = 1; i < N; i++) begin
        ev = model_vec(i); dv = dut_vec(i);
        checks++;
        if (dv !== ev) begin
          errors++;
          $display("FAIL switch_video inst=%0d k=%0d got=%h exp=%h", i, k[i], dv, ev);
        end
      end
      if (vbp[1]) begin
        checks++;
        if (pulses == 0) begin
          if (af[1] !== 1'b1) begin
            errors++;
            $display("FAIL switch_latch got=%b exp=1", af[1]);
          end
        end else if (c - last_pulse != flen(1)) begin
          errors++;
          $display("FAIL vblank_period got=%0d exp=%0d", c - last_pulse, flen(1));
        end
        pulses++;
        last_pulse = c;
      end else if (pulses == 0) begin
        checks++;
        if (af[1] !== 1'b0) begin
          errors++;
          $display("FAIL switch_early got=%b exp=0", af[1]);
        end
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL vblank_count got=%0d exp=3", pulses);
    end
  endtask

  task automatic test_reset_midframe(int i, int th, int tv);
    int p, first_low, low_cnt, exp_first;
    logic found, prev;
    logic [49:0] ev, dv;
    found = 1'b0;
    for (int c = 0; c < 2500; c++) begin
      p = k[i] % flen(i);
      if (p % ht(i) == th && (tv < 0 || p / ht(i) == tv)) begin found = 1'b1; break; end
      step();
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL midreset_wait inst=%0d got=timeout exp=position", i);
    end
    rst[i] = 1'b1; k[i] = 0; af_m[i] = 1'b0; vb_m[i] = 1'b0;
    #1;
    checks++;
    if (dut_vec(i) !== RESET_VEC) begin
      errors++;
      $display("FAIL midreset_async inst=%0d got=%h exp=%h", i, dut_vec(i), RESET_VEC);
    end
    repeat (3) step();
    checks++;
    if (dut_vec(i) !== RESET_VEC) begin
      errors++;
      $display("FAIL midreset_hold inst=%0d got=%h exp=%h", i, dut_vec(i), RESET_VEC);
    end
    rst[i] = 1'b0;
    first_low = -1; low_cnt = 0; prev = 1'b1;
    for (int c = 0; c < 3 * ht(i); c++) begin
      step();
      ev = model_vec(i); dv = dut_vec(i);
      checks++;
      if (dv !== ev) begin
        errors++;
        $display("FAIL midreset_video inst=%0d k=%0d got=%h exp=%h", i, k[i], dv, ev);
      end
      if (prev && !hs_n[i] && first_low < 0) first_low = k[i];
      if (!hs_n[i]) low_cnt++;
      prev = hs_n[i];
    end
    exp_first = HV_A[i] + HF_A[i] + RL_A[i] + 1;
    checks++;
    if (first_low != exp_first) begin
      errors++;
      $display("FAIL midreset_first_low inst=%0d got=%0d exp=%0d", i, first_low, exp_first);
    end
    checks++;
    if (low_cnt != 3 * HS_A[i]) begin
      errors++;
      $display("FAIL midreset_low_cycles inst=%0d got=%0d exp=%0d", i, low_cnt, 3 * HS_A[i]);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_hsync_timing();
    test_colour();
    test_frame_switch();
    test_reset_midframe(0, 400, -1);
    test_reset_midframe(1, 25, 8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_controller.md
# vga_controller

Pixel-timing generator and video output stage for the 640x480@60 Hz VGA port, driven by the 25 MHz video clock. Produces the pixel coordinates consumed by the framebuffer interface and receives both 8-bit frame pixels plus the frame-select bit. Expands the selected BBGGGRRR pixel to 24-bit RGB for the board DAC, with sync and blank signals. Latches the frame selection once per frame at the start of vertical blanking to avoid tearing, and emits a one-cycle vblank pulse for the core.

## Interface
Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16; H_SYNC, 96; H_BACK, 48, horizontal porches/sync (line total 800)
- V_VISIBLE, 480, visible lines
- V_FRONT, 10; V_SYNC, 2; V_BACK, 33, vertical porches/sync (frame total 525)
- READ_LATENCY, 1, clock_video cycles from pixel_x_pos/pixel_y_pos to valid pixel_frame0/1 (range 1..3)

Ports:
- clock_video  in  1  pixel clock, 25 MHz; the only clock
- reset  in  1  asynchronous, active-high
- pixel_x_pos  out  10  horizontal coordinate to framebuffer (0..639)
- pixel_y_pos  out  10  vertical coordinate to framebuffer (0..479)
- pixel_frame0  in  8  frame 0 pixel, BBGGGRRR
- pixel_frame1  in  8  frame 1 pixel, BBGGGRRR
- frame_select  in  1  requested display frame (0/1)
- vga_r, vga_g, vga_b  out  8 each  DAC colour
- vga_hsync_n, vga_vsync_n  out  1  negative-polarity syncs
- vga_blank_n  out  1  low outside the visible area
- vga_sync_n  out  1  constant 0 (no sync-on-green)
- active_frame  out  1  frame currently displayed
- vblank_pulse  out  1  one-cycle pulse at start of vertical blanking

## Operation
- h_count 0..799 increments every cycle and wraps to 0; v_count 0..524 increments when h_count wraps and itself wraps to 0 after 524.
- Visible when h_count < 640 and v_count < 480. pixel_x_pos/pixel_y_pos = h_count/v_count when visible, else 0.
- hsync active (low) for h_count 656..751; vsync active for v_count 490..491. Polarity is independent of visibility.
- visible, hsync, vsync pass through a READ_LATENCY-deep delay line so they align with the returned pixel data.
- Pixel select: delayed active_frame ? pixel_frame1 : pixel_frame0. Colour expansion of P = BBGGGRRR:
  - vga_r = {P[2:0],P[2:0],P[2:1]}
  - vga_g = {P[5:3],P[5:3],P[5:4]}
  - vga_b = {P[7:6],P[7:6],P[7:6],P[7:6]}
- RGB is forced to 0 when the delayed visible flag is 0.
- Frame latch: when (h_count,v_count) = (0,480), active_frame <= frame_select and vblank_pulse is asserted on the next cycle for exactly one cycle. A frame_select change at any other time takes effect only at the next (0,480).

## Timing
- Counters, delay line and all video outputs are registered.
- Video outputs (rgb, syncs, blank_n) for coordinate (h,v) appear READ_LATENCY+1 cycles after the counters hold (h,v). pixel_x_pos/pixel_y_pos are combinational from the counters (0 latency).
- Reset values (asynchronous, held while reset=1):
  - counters 0; pixel_x_pos/y_pos 0
  - rgb 0; vga_hsync_n 1; vga_vsync_n 1; vga_blank_n 0; vga_sync_n 0
  - active_frame 0; vblank_pulse 0; delay line cleared to not-visible, sync-inactive
- Reset deassertion mid-frame restarts at (0,0). The first visible pixel reaches the outputs READ_LATENCY+1 cycles after the first edge following reset release.
- Frame period is exactly 800*525 = 420000 cycles, and vblank_pulse period is also 420000.

## Test plan
- Reset then run 1 frame: vga_hsync_n low for 96 cycles every 800, the first low edge 656+READ_LATENCY+1 cycles after release; vga_vsync_n low for 1600 cycles per 420000.
- READ_LATENCY=1; pixel_frame0 driven as a model of a registered RAM returning {x[7:0]} for each address; frame_select=0: vga_r/g/b at output cycle for x=5 equals the expansion of 8'h05 (r=8'hB6, g=0, b=0); blank_n low and rgb 0 at x=640..799.
- Colour expansion: pixel 8'hFF -> rgb FF/FF/FF; 8'hC0 -> 00/00/FF; 8'h38 -> 00/FF/00; 8'h07 -> FF/00/00.
- Toggle frame_select to 1 at (320,100): active_frame stays 0 until (0,480), then becomes 1 with a single-cycle vblank_pulse; output switches to pixel_frame1 from line 0 of the next frame.
- Assert reset at (400,300) for 3 cycles: all outputs take their reset values immediately (asynchronously); after release counting restarts at (0,0) and the sync period is correct.
- READ_LATENCY=3: sync/blank/rgb alignment shifts by 2 cycles relative to READ_LATENCY=1, and the pixel-to-coordinate correspondence is still exact.
